// File: rtl/buffer_pkg.sv
// Shared types and default widths for the MAC circular slot buffer (read and write sides).
package buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } rd_state_t;

  localparam int BUF_WIDTH_DEF  = 2;
  localparam int BUF_SIZE_DEF   = 4;
  localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/ring_ptr.sv
// Circular slot pointer: Width-bit address plus a wrap bit that flips on each wrap to zero.
module ring_ptr #(
  parameter int Width = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [Width-1:0] o_addr,
  output logic             o_wrap
);

  logic [Width-1:0] r_addr;
  logic             r_wrap;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_addr <= '0;
      r_wrap <= 1'b0;
    end else if (i_inc) begin
      r_addr <= r_addr + Width'(1);
      if (&r_addr) r_wrap <= ~r_wrap;
    end
  end

  assign o_addr = r_addr;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/buffer_reader.sv
// Read-side controller for the MAC slot buffer: fetches ready slots and streams them over valid/ready.
// Optional macro RD_CLEAR_EN enables the one-hot Clear pulse for the slot just delivered.
module buffer_reader
  import buffer_pkg::*;
#(
  parameter int BufferWidth = BUF_WIDTH_DEF,
  parameter int BufferSize  = BUF_SIZE_DEF,
  parameter int DataWidth   = DATA_WIDTH_DEF
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [BufferSize-1:0]  Ready,
  output logic [BufferWidth-1:0] R_Addr,
  output logic                   Round,
  output logic                   Rd_En,
  input  logic [DataWidth-1:0]   Rd_Data,
  output logic [DataWidth-1:0]   Out_Data,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [BufferSize-1:0]  Clear
);

  rd_state_t              r_state;
  logic [DataWidth-1:0]   r_out_data;
  logic                   r_out_valid;
  logic [BufferWidth-1:0] w_addr;
  logic                   w_round;
  logic                   w_slot_ready;
  logic                   w_xfer;
  logic                   w_inc;

  assign w_slot_ready = Ready[w_addr];
  assign w_xfer       = r_out_valid & Out_Ready;
  assign w_inc        = (r_state == READ);

  ring_ptr #(
    .Width (BufferWidth)
  ) u_ptr (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_inc   (w_inc),
    .o_addr  (w_addr),
    .o_wrap  (w_round)
  );

  // Read strobe is combinational so the RAM samples R_Addr in the same cycle the slot is seen ready.
  always_comb begin
    Rd_En = 1'b0;
    case (r_state)
      IDLE:    Rd_En = w_slot_ready;
      HOLD:    Rd_En = w_xfer & w_slot_ready;
      default: Rd_En = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_slot_ready) r_state <= READ;
        READ: begin
          r_out_data  <= Rd_Data;
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: if (w_xfer) begin
          r_out_valid <= 1'b0;
          r_state     <= w_slot_ready ? READ : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign R_Addr    = w_addr;
  assign Round     = w_round;
  assign Out_Data  = r_out_data;
  assign Out_Valid = r_out_valid;

`ifdef RD_CLEAR_EN
  // The pointer has already advanced past the held word, so its slot is one behind.
  localparam logic [BufferSize-1:0] SLOT_ONE = BufferSize'(1);
  logic [BufferWidth-1:0] w_prev_addr;

  assign w_prev_addr = w_addr - BufferWidth'(1);
  assign Clear       = w_xfer ? (SLOT_ONE << w_prev_addr) : '0;
`else
  assign Clear = '0;
`endif

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader with a 1-cycle synchronous RAM model on the read port.
module tb_buffer_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ready;
  logic [1:0] r_addr;
  logic       round;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] clear;

  logic [7:0] mem [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[r_addr];

  buffer_reader #(
    .BufferWidth (2),
    .BufferSize  (4),
    .DataWidth   (8)
  ) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .Ready     (ready),
    .R_Addr    (r_addr),
    .Round     (round),
    .Rd_En     (rd_en),
    .Rd_Data   (rd_data),
    .Out_Data  (out_data),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Clear     (clear)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 4'b0000; out_ready = 1'b0;
    tick(); tick();
    checks++; if (r_addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", r_addr); end
    checks++; if (round !== 1'b0) begin errors++; $display("FAIL reset_round: got %0b want 0", round); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rden: got %0b want 0", rd_en); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h want 00", out_data); end
    checks++; if (clear !== 4'b0000) begin errors++; $display("FAIL reset_clear: got %b want 0000", clear); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    ready = 4'b0001; out_ready = 1'b1; #1;
    checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL single_rden_idle: got %0b want 1", rd_en); end
    tick();
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL single_rden_read: got %0b want 0", rd_en); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_read: got %0b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h want a5", out_data); end
    checks++; if (r_addr !== 2'd1) begin errors++; $display("FAIL single_addr: got %0d want 1", r_addr); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL single_rden_hold: got %0b want 0", rd_en); end
`ifdef RD_CLEAR_EN
    checks++; if (clear !== 4'b0001) begin errors++; $display("FAIL single_clear: got %b want 0001", clear); end
`else
    checks++; if (clear !== 4'b0000) begin errors++; $display("FAIL single_clear: got %b want 0000", clear); end
`endif
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after: got %0b want 0", out_valid); end
    checks++; if (r_addr !== 2'd1) begin errors++; $display("FAIL single_addr_after: got %0d want 1", r_addr); end
    ready = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_addr;
    logic [3:0] exp_clr;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    ready = 4'b1111; out_ready = 1'b1; #1;
    checks++; if (rd_en !== 1'b1 || r_addr !== 2'd0) begin errors++; $display("FAIL b2b_start: got rd_en=%0b addr=%0d want 1/0", rd_en, r_addr); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d: got %0b want 0", k, out_valid); end
      tick();
      exp_addr = 2'(k + 1);
      exp_clr  = 4'b0001 << k;
      checks++; if (out_valid !== 1'b1 || out_data !== mem[k]) begin errors++; $display("FAIL b2b_word%0d: got v=%0b d=%0h want 1/%0h", k, out_valid, out_data, mem[k]); end
      checks++; if (r_addr !== exp_addr) begin errors++; $display("FAIL b2b_addr%0d: got %0d want %0d", k, r_addr, exp_addr); end
      checks++; if (round !== (k == 3)) begin errors++; $display("FAIL b2b_round%0d: got %0b want %0b", k, round, (k == 3)); end
      checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL b2b_rden%0d: got %0b want 1", k, rd_en); end
`ifdef RD_CLEAR_EN
      checks++; if (clear !== exp_clr) begin errors++; $display("FAIL b2b_clear%0d: got %b want %b", k, clear, exp_clr); end
`else
      checks++; if (clear !== 4'b0000) begin errors++; $display("FAIL b2b_clear%0d: got %b want 0000 (exp slot %b)", k, clear, exp_clr); end
`endif
    end
  endtask

  task automatic test_hold();
    out_ready = 1'b0; #1;
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL hold_rden0: got %0b want 0", rd_en); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== mem[3]) begin errors++; $display("FAIL hold_word%0d: got v=%0b d=%0h want 1/%0h", c, out_valid, out_data, mem[3]); end
      checks++; if (rd_en !== 1'b0 || r_addr !== 2'd0) begin errors++; $display("FAIL hold_ctl%0d: got rd_en=%0b addr=%0d want 0/0", c, rd_en, r_addr); end
      checks++; if (clear !== 4'b0000) begin errors++; $display("FAIL hold_clear%0d: got %b want 0000", c, clear); end
    end
    ready = 4'b0000; out_ready = 1'b1; #1;
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL hold_rden_release: got %0b want 0", rd_en); end
`ifdef RD_CLEAR_EN
    checks++; if (clear !== 4'b1000) begin errors++; $display("FAIL hold_clear_release: got %b want 1000", clear); end
`else
    checks++; if (clear !== 4'b0000) begin errors++; $display("FAIL hold_clear_release: got %b want 0000", clear); end
`endif
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid_release: got %0b want 0", out_valid); end
  endtask

  task automatic test_empty();
    ready = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (rd_en !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL empty%0d: got rd_en=%0b v=%0b want 0/0", c, rd_en, out_valid); end
      checks++; if (r_addr !== 2'd0) begin errors++; $display("FAIL empty_addr%0d: got %0d want 0", c, r_addr); end
    end
  endtask

  task automatic test_ready_drop();
    ready = 4'b0001; out_ready = 1'b1; #1;
    tick();
    ready = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== mem[0]) begin errors++; $display("FAIL drop_word: got v=%0b d=%0h want 1/%0h", out_valid, out_data, mem[0]); end
    checks++; if (r_addr !== 2'd1 || round !== 1'b1) begin errors++; $display("FAIL drop_ptr: got addr=%0d round=%0b want 1/1", r_addr, round); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_after: got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_hold();
    ready = 4'b0110; out_ready = 1'b1; #1;
    tick(); tick();
    checks++; if (out_data !== mem[1] || rd_en !== 1'b1) begin errors++; $display("FAIL rsth_first: got d=%0h rd_en=%0b want %0h/1", out_data, rd_en, mem[1]); end
    tick();
    out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== mem[2]) begin errors++; $display("FAIL rsth_held: got v=%0b d=%0h want 1/%0h", out_valid, out_data, mem[2]); end
    checks++; if (r_addr !== 2'd3 || round !== 1'b1) begin errors++; $display("FAIL rsth_ptr: got addr=%0d round=%0b want 3/1", r_addr, round); end
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rsth_out: got v=%0b d=%0h want 0/00", out_valid, out_data); end
    checks++; if (r_addr !== 2'd0 || round !== 1'b0) begin errors++; $display("FAIL rsth_ptr_rst: got addr=%0d round=%0b want 0/0", r_addr, round); end
    checks++; if (clear !== 4'b0000 || rd_en !== 1'b0) begin errors++; $display("FAIL rsth_ctl: got clear=%b rd_en=%0b want 0000/0", clear, rd_en); end
    rst_n = 1'b1; ready = 4'b0000; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rsth_no_replay: got %0b want 0", out_valid); end
  endtask

  task automatic test_clear_slot2();
    ready = 4'b0111; out_ready = 1'b1; #1;
    for (int c = 0; c < 6; c++) tick();
    checks++; if (out_valid !== 1'b1 || out_data !== mem[2]) begin errors++; $display("FAIL clr2_word: got v=%0b d=%0h want 1/%0h", out_valid, out_data, mem[2]); end
`ifdef RD_CLEAR_EN
    checks++; if (clear !== 4'b0100) begin errors++; $display("FAIL clr2_clear: got %b want 0100", clear); end
`else
    checks++; if (clear !== 4'b0000) begin errors++; $display("FAIL clr2_clear: got %b want 0000", clear); end
`endif
    ready = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b0 || r_addr !== 2'd3) begin errors++; $display("FAIL clr2_after: got v=%0b addr=%0d want 0/3", out_valid, r_addr); end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h5A; mem[3] = 8'hC3;
    rst_n = 1'b0; ready = 4'b0000; out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_empty();
    test_ready_drop();
    test_reset_hold();
    test_clear_slot2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
